selftrig_fill_parser: RTL

SELFTRIG_FILL_PARSER -- requirements
Module: selftrig_fill_parser

---
 rtl/selftrig_fmt_pkg.sv | 75 +++++++
 rtl/selftrig_xor_chk.sv | 27 ++
 rtl/selftrig_fill_parser.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/selftrig_fmt_pkg.sv
// Purpose: shared self-trigger fill format (tags, header pattern, field slices, FSM states).
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package selftrig_fmt_pkg;

  // Burst tags carried in in_dat[131:128]
  localparam logic [3:0] TAG_FILL = 4'd1;
  localparam logic [3:0] TAG_WFM  = 4'd2;
  localparam logic [3:0] TAG_DATA = 4'd3;
  localparam logic [3:0] TAG_CHK  = 4'd4;

  // Both header kinds carry this marker in payload [127:126]
  localparam logic [1:0] HDR_PAT     = 2'b01;
  localparam int         HDR_PAT_LSB = 126;

  // Fill header slices
  localparam int FILL_NUM_LSB  = 0;    // 24 bits
  localparam int FILL_TYPE_LSB = 24;   // 2 bits
  localparam int NFB_LSB       = 27;   // 23 bits
  localparam int NWB_LSB       = 50;   // 14 bits
  localparam int PRE_LO_LSB    = 64;   // pre_trig[11:0]
  localparam int NWF_LSB       = 76;   // 23 bits
  localparam int PRE_HI_LSB    = 99;   // pre_trig[15:12]
  localparam int CHTAG_LSB     = 110;  // 12 bits

  // Waveform header slices
  localparam int WFM_BURSTS_LSB = 0;   // 14 bits, echo of num_wfm_bursts
  localparam int WFM_START_LSB  = 26;  // 23 bits
  localparam int WFM_NUM_LSB    = 49;  // 23 bits
  localparam int TRIG_LO_LSB    = 72;  // trigger_time[25:0]
  localparam int TRIG_HI_LSB    = 110; // trigger_time[41:26]

  // Data word: eight 16-bit lanes, each a sign-extended 12-bit sample
  localparam int N_LANES  = 8;
  localparam int LANE_W   = 16;
  localparam int SAMPLE_W = 12;
  localparam int EXT_W    = LANE_W - SAMPLE_W;

  typedef enum logic [2:0] {
    ST_SEEK,
    ST_FILL_HDR_WAIT,
    ST_WFM_HDR,
    ST_DATA,
    ST_CHECKSUM,
    ST_SEEK_ERR
  } state_t;

  typedef struct packed {
    logic len;
    logic checksum;
    logic wfm_seq;
    logic sign_ext;
    logic hdr_pattern;
    logic tag;
  } err_t;

  // True when any lane's upper bits are not copies of its sample sign bit
  function automatic logic sign_ext_bad(input logic [127:0] p);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < N_LANES; k++) begin
      if (p[LANE_W*k+SAMPLE_W +: EXT_W] != {EXT_W{p[LANE_W*k+SAMPLE_W-1]}}) bad = 1'b1;
    end
    return bad;
  endfunction

  // Drop the extension bits, oldest sample in the low lane
  function automatic logic [N_LANES*SAMPLE_W-1:0] pack_samples(input logic [127:0] p);
    logic [N_LANES*SAMPLE_W-1:0] s;
    s = '0;
    for (int k = 0; k < N_LANES; k++) s[SAMPLE_W*k +: SAMPLE_W] = p[LANE_W*k +: SAMPLE_W];
    return s;
  endfunction

endpackage

// File: rtl/selftrig_xor_chk.sv
// Purpose: 128-bit running XOR over a fill, compared against the checksum word.
// Latency: accumulator updates 1 cycle after clr/upd; match is combinational on acc.
// Backpressure: none; the caller only strobes clr/upd on accepted words.
module selftrig_xor_chk (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         upd,
  input  logic [127:0] upd_dat,
  input  logic [127:0] cmp_dat,
  output logic         match
);

  logic [127:0] acc;

  // clr and upd together restart the sum seeded with the fill header payload
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (clr || upd) begin
      acc <= (clr ? 128'd0 : acc) ^ (upd ? upd_dat : 128'd0);
    end
  end

  assign match = (acc == cmp_dat);

endmodule

// File: rtl/selftrig_fill_parser.sv
// Purpose: parse DDR3 self-trigger fills into fill/waveform headers, samples and error status.
// Latency: every output registered, 1 cycle after the word is accepted.
// Backpressure: in_ready drops only while a sample is held and sample_ready is low.
module selftrig_fill_parser
  import selftrig_fmt_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [131:0] in_dat,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         fill_hdr_valid,
  output logic [23:0]  fill_num,
  output logic [1:0]   fill_type,
  output logic [22:0]  num_fill_bursts,
  output logic [13:0]  num_wfm_bursts,
  output logic [15:0]  pre_trig,
  output logic [22:0]  num_waveforms,
  output logic [11:0]  channel_tag,
  output logic         wfm_hdr_valid,
  output logic [22:0]  wfm_num,
  output logic [22:0]  wfm_start_adr,
  output logic [41:0]  trigger_time,
  output logic [95:0]  sample_dat,
  output logic         sample_valid,
  input  logic         sample_ready,
  output logic         fill_done,
  output logic [5:0]   err_flags,
  output logic [15:0]  err_count
);

  state_t       state;
  err_t         err_q;
  logic [22:0]  wfm_cnt;
  logic [22:0]  word_cnt;
  logic [22:0]  prev_wfm_num;
  logic [13:0]  data_cnt;
  logic         first_wfm;

  logic [3:0]   tag;
  logic [127:0] pl;
  logic         accept, in_fill, is_fill, tag_bad, hdr_bad, wfm_seq_bad, sext_bad;
  logic         go_wfm, go_data, go_chk, chk_match, len_bad, word_err;
  logic [3:0]   exp_tag;
  logic [22:0]  w_num, wfm_cnt_inc, word_cnt_inc;

  assign tag      = in_dat[131:128];
  assign pl       = in_dat[127:0];
  assign in_ready = reset || !(sample_valid && !sample_ready);
  assign accept   = in_valid && in_ready && !reset;
  assign err_flags = err_q;

  // Tag the current state is waiting for; seek states only look for fill headers
  always_comb begin
    exp_tag = TAG_FILL;
    case (state)
      ST_WFM_HDR:  exp_tag = TAG_WFM;
      ST_DATA:     exp_tag = TAG_DATA;
      ST_CHECKSUM: exp_tag = TAG_CHK;
      default:     exp_tag = TAG_FILL;
    endcase
  end

  assign in_fill  = (state == ST_WFM_HDR) || (state == ST_DATA) || (state == ST_CHECKSUM);
  assign is_fill  = (tag == TAG_FILL);
  assign tag_bad  = in_fill && !is_fill && (tag != exp_tag);
  assign go_wfm   = accept && (state == ST_WFM_HDR)  && (tag == TAG_WFM);
  assign go_data  = accept && (state == ST_DATA)     && (tag == TAG_DATA);
  assign go_chk   = accept && (state == ST_CHECKSUM) && (tag == TAG_CHK);

  assign hdr_bad     = (pl[HDR_PAT_LSB +: 2] != HDR_PAT);
  assign w_num       = pl[WFM_NUM_LSB +: 23];
  assign wfm_seq_bad = (pl[WFM_BURSTS_LSB +: 14] != num_wfm_bursts) ||
                       (!first_wfm && (w_num != prev_wfm_num + 23'd1));
  assign sext_bad    = sign_ext_bad(pl);

  assign wfm_cnt_inc  = (wfm_cnt  == '1) ? wfm_cnt  : wfm_cnt  + 23'd1;
  assign word_cnt_inc = (word_cnt == '1) ? word_cnt : word_cnt + 23'd1;
  assign len_bad      = (word_cnt_inc != num_fill_bursts);

  assign word_err = accept && (is_fill ? (hdr_bad || in_fill)
                                       : (tag_bad ||
                                          (go_wfm  && (hdr_bad || wfm_seq_bad)) ||
                                          (go_data && sext_bad) ||
                                          (go_chk  && (!chk_match || len_bad))));

  selftrig_xor_chk u_xor (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept && is_fill),
    .upd     (accept && is_fill || go_wfm || go_data),
    .upd_dat (pl),
    .cmp_dat (pl),
    .match   (chk_match)
  );

  // Fill FSM with registered header fields, samples, pulses and error status
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_SEEK;
      err_q           <= '0;
      err_count       <= '0;
      wfm_cnt         <= '0;
      word_cnt        <= '0;
      prev_wfm_num    <= '0;
      data_cnt        <= '0;
      first_wfm       <= 1'b1;
      fill_hdr_valid  <= 1'b0;
      fill_num        <= '0;
      fill_type       <= '0;
      num_fill_bursts <= '0;
      num_wfm_bursts  <= '0;
      pre_trig        <= '0;
      num_waveforms   <= '0;
      channel_tag     <= '0;
      wfm_hdr_valid   <= 1'b0;
      wfm_num         <= '0;
      wfm_start_adr   <= '0;
      trigger_time    <= '0;
      sample_dat      <= '0;
      sample_valid    <= 1'b0;
      fill_done       <= 1'b0;
    end else begin
      fill_hdr_valid <= 1'b0;
      wfm_hdr_valid  <= 1'b0;
      fill_done      <= 1'b0;
      if (sample_ready) sample_valid <= 1'b0;
      if (word_err && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;

      if (accept) begin
        if (is_fill) begin
          // A fill header always restarts; cutting a live fill short is a tag error
          err_q           <= '{len: 1'b0, checksum: 1'b0, wfm_seq: 1'b0, sign_ext: 1'b0,
                               hdr_pattern: hdr_bad, tag: in_fill};
          fill_hdr_valid  <= 1'b1;
          fill_num        <= pl[FILL_NUM_LSB +: 24];
          fill_type       <= pl[FILL_TYPE_LSB +: 2];
          num_fill_bursts <= pl[NFB_LSB +: 23];
          num_wfm_bursts  <= pl[NWB_LSB +: 14];
          pre_trig        <= {pl[PRE_HI_LSB +: 4], pl[PRE_LO_LSB +: 12]};
          num_waveforms   <= pl[NWF_LSB +: 23];
          channel_tag     <= pl[CHTAG_LSB +: 12];
          word_cnt        <= 23'd1;
          wfm_cnt         <= '0;
          data_cnt        <= '0;
          first_wfm       <= 1'b1;
          state           <= (pl[NWF_LSB +: 23] == 23'd0) ? ST_CHECKSUM : ST_WFM_HDR;
        end else if (tag_bad) begin
          err_q.tag <= 1'b1;
          state     <= ST_SEEK_ERR;
        end else if (go_wfm) begin
          if (hdr_bad)     err_q.hdr_pattern <= 1'b1;
          if (wfm_seq_bad) err_q.wfm_seq     <= 1'b1;
          wfm_hdr_valid <= 1'b1;
          wfm_num       <= w_num;
          wfm_start_adr <= pl[WFM_START_LSB +: 23];
          trigger_time  <= {pl[TRIG_HI_LSB +: 16], pl[TRIG_LO_LSB +: 26]};
          prev_wfm_num  <= w_num;
          first_wfm     <= 1'b0;
          word_cnt      <= word_cnt_inc;
          wfm_cnt       <= wfm_cnt_inc;
          data_cnt      <= '0;
          if (num_wfm_bursts != 14'd0)             state <= ST_DATA;
          else if (wfm_cnt_inc >= num_waveforms)   state <= ST_CHECKSUM;
          else                                     state <= ST_WFM_HDR;
        end else if (go_data) begin
          if (sext_bad) err_q.sign_ext <= 1'b1;
          sample_dat   <= pack_samples(pl);
          sample_valid <= 1'b1;
          word_cnt     <= word_cnt_inc;
          data_cnt     <= data_cnt + 14'd1;
          if (data_cnt + 14'd1 == num_wfm_bursts)
            state <= (wfm_cnt >= num_waveforms) ? ST_CHECKSUM : ST_WFM_HDR;
        end else if (go_chk) begin
          if (!chk_match) err_q.checksum <= 1'b1;
          if (len_bad)    err_q.len      <= 1'b1;
          word_cnt  <= word_cnt_inc;
          fill_done <= 1'b1;
          state     <= ST_SEEK;
        end
        // Seek states drop everything that is not a fill header
      end
    end
  end

endmodule
